// File: rtl/cmd_encode_pkg.sv
// Shared types, widths and command codes for the 8-byte host command issuer.
package cmd_encode_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned ADDR_W  = 24;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned FRAME_W = 64;
    localparam int unsigned TMO_W   = 20;
    localparam int unsigned BCNT_W  = 3;
    localparam int unsigned RLEN_W  = 2;

    // Action / target / mode codes shared with the responder (RS232_Command.h)
    localparam logic [BYTE_W-1:0] ACT_WRITE    = 8'h01;
    localparam logic [BYTE_W-1:0] ACT_READ     = 8'h02;
    localparam logic [BYTE_W-1:0] TGT_LED      = 8'hF0;
    localparam logic [BYTE_W-1:0] TGT_SDRAM    = 8'h1F;
    localparam logic [BYTE_W-1:0] TGT_FLASH    = 8'h0F;
    localparam logic [BYTE_W-1:0] MODE_NORMAL  = 8'h00;
    localparam logic [BYTE_W-1:0] MODE_DISPLAY = 8'h33;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_RSP,
        ST_DONE
    } state_t;

    // Field order equals wire order: action goes out first (MSB-first frame)
    typedef struct packed {
        logic [BYTE_W-1:0] action;
        logic [BYTE_W-1:0] target;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BYTE_W-1:0] mode;
    } cmd_frame_t;

    function automatic logic [RLEN_W-1:0] norm_rsp_len(input logic [RLEN_W-1:0] len);
        return (len == 2'd3) ? 2'd2 : len;
    endfunction

endpackage

// File: rtl/cmd_encode_timeout_cnt.sv
// Response timeout counter: counts enabled cycles, flags the cycle the limit is reached.
module cmd_timeout_cnt
    import cmd_encode_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1048575
) (
    input  logic iCLK,
    input  logic iRST_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expire_c
);

    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + TMO_W'(1);
        end
    end

    // A clear in the same cycle suppresses expiry, so a late byte always wins
    assign o_expire_c = i_en && !i_clr && (r_cnt == TMO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/cmd_encode.sv
// Host command issuer: serializes one 64-bit command as 8 bytes, then gathers up to 2 response bytes.
module cmd_encode
    import cmd_encode_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1048575
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iReq,
    output logic              oAck,
    input  logic [BYTE_W-1:0] iAction,
    input  logic [BYTE_W-1:0] iTarget,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic [DATA_W-1:0] iData,
    input  logic [BYTE_W-1:0] iMode,
    input  logic [RLEN_W-1:0] iRsp_Len,
    output logic [BYTE_W-1:0] oTXD_DATA,
    output logic              oTXD_Start,
    input  logic              iTXD_Done,
    input  logic [BYTE_W-1:0] iRXD_DATA,
    input  logic              iRXD_Ready,
    output logic [DATA_W-1:0] oRsp_DATA,
    output logic              oRsp_Valid,
    output logic              oTimeout,
    output logic              oBusy
);

    state_t             r_state;
    logic [FRAME_W-1:0] r_frame;
    logic [BCNT_W-1:0]  r_byte_cnt;
    logic [RLEN_W-1:0]  r_rsp_len;
    logic [RLEN_W-1:0]  r_rsp_cnt;
    logic [BYTE_W-1:0]  r_txd_data;
    logic               r_txd_start;
    logic [DATA_W-1:0]  r_rsp_data;
    logic               r_ack;
    logic               r_rsp_valid;
    logic               r_timeout;
    logic               r_busy;

    cmd_frame_t         w_cmd;
    logic [RLEN_W-1:0]  w_rsp_cnt_nxt;
    logic               w_tmo_en;
    logic               w_tmo_clr;
    logic               w_expire;

    assign w_cmd = '{action: iAction, target: iTarget, addr: iAddr, data: iData, mode: iMode};
    assign w_rsp_cnt_nxt = r_rsp_cnt + RLEN_W'(1);

    // Timeout window only runs in RSP and restarts on every received byte
    assign w_tmo_en  = (r_state == ST_RSP);
    assign w_tmo_clr = (r_state != ST_RSP) || iRXD_Ready;

    cmd_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .iCLK       (iCLK),
        .iRST_n     (iRST_n),
        .i_en       (w_tmo_en),
        .i_clr      (w_tmo_clr),
        .o_expire_c (w_expire)
    );

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state     <= ST_IDLE;
            r_frame     <= '0;
            r_byte_cnt  <= '0;
            r_rsp_len   <= '0;
            r_rsp_cnt   <= '0;
            r_txd_data  <= '0;
            r_txd_start <= 1'b0;
            r_rsp_data  <= '0;
            r_ack       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_ack       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_timeout   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (iReq) begin
                        r_frame    <= w_cmd;
                        r_rsp_len  <= norm_rsp_len(iRsp_Len);
                        r_rsp_cnt  <= '0;
                        r_byte_cnt <= '0;
                        r_rsp_data <= '0;
                        r_ack      <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!r_txd_start) begin
                        r_txd_start <= 1'b1;
                        r_txd_data  <= r_frame[FRAME_W-1 -: BYTE_W];
                    end else if (iTXD_Done) begin
                        r_txd_start <= 1'b0;
                        r_frame     <= {r_frame[FRAME_W-BYTE_W-1:0], BYTE_W'(0)};
                        r_byte_cnt  <= r_byte_cnt + BCNT_W'(1);
                        r_state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // Counter wrapped to 0 means all 8 bytes are out
                    if (r_byte_cnt == '0) begin
                        if (r_rsp_len != '0) begin
                            r_state <= ST_RSP;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= ST_DONE;
                        end
                    end else begin
                        r_txd_start <= 1'b1;
                        r_txd_data  <= r_frame[FRAME_W-1 -: BYTE_W];
                        r_state     <= ST_SEND;
                    end
                end
                ST_RSP: begin
                    if (iRXD_Ready) begin
                        if (r_rsp_cnt == '0) begin
                            r_rsp_data[BYTE_W-1:0] <= iRXD_DATA;
                        end else begin
                            r_rsp_data[DATA_W-1:BYTE_W] <= iRXD_DATA;
                        end
                        r_rsp_cnt <= w_rsp_cnt_nxt;
                        if (w_rsp_cnt_nxt == r_rsp_len) begin
                            r_rsp_valid <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= ST_DONE;
                        end
                    end else if (w_expire) begin
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                // Completion pulse is raised on entry, so DONE just returns home
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign oAck       = r_ack;
    assign oTXD_DATA  = r_txd_data;
    assign oTXD_Start = r_txd_start;
    assign oRsp_DATA  = r_rsp_data;
    assign oRsp_Valid = r_rsp_valid;
    assign oTimeout   = r_timeout;
    assign oBusy      = r_busy;

endmodule

// File: tb/tb_cmd_encode.sv
// Scoreboard bench for cmd_encode: byte order, gap timing, responses, timeout and reset.
module tb_cmd_encode;
    import cmd_encode_pkg::*;

    logic        iCLK = 1'b0;
    logic        iRST_n;
    logic        iReq;
    logic        oAck;
    logic [7:0]  iAction, iTarget, iMode;
    logic [23:0] iAddr;
    logic [15:0] iData;
    logic [1:0]  iRsp_Len;
    logic [7:0]  oTXD_DATA;
    logic        oTXD_Start;
    logic        iTXD_Done;
    logic [7:0]  iRXD_DATA;
    logic        iRXD_Ready;
    logic [15:0] oRsp_DATA;
    logic        oRsp_Valid;
    logic        oTimeout;
    logic        oBusy;

    int checks = 0;
    int errors = 0;
    int val_cnt = 0;
    int tmo_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] rsp_q[$];

    cmd_encode #(.TIMEOUT_CYC(100)) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iReq(iReq), .oAck(oAck),
        .iAction(iAction), .iTarget(iTarget), .iAddr(iAddr), .iData(iData), .iMode(iMode),
        .iRsp_Len(iRsp_Len), .oTXD_DATA(oTXD_DATA), .oTXD_Start(oTXD_Start), .iTXD_Done(iTXD_Done),
        .iRXD_DATA(iRXD_DATA), .iRXD_Ready(iRXD_Ready), .oRsp_DATA(oRsp_DATA),
        .oRsp_Valid(oRsp_Valid), .oTimeout(oTimeout), .oBusy(oBusy)
    );

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) begin
        #1;
        if (oRsp_Valid) val_cnt++;
        if (oTimeout) tmo_cnt++;
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] t, input logic [23:0] ad,
                         input logic [15:0] d, input logic [7:0] m, input logic [1:0] len,
                         input logic [15:0] exp_rsp);
        bit got = 0;
        iAction = a; iTarget = t; iAddr = ad; iData = d; iMode = m; iRsp_Len = len;
        iReq = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (oAck) begin got = 1; break; end
        end
        iReq = 1'b0;
        checks++;
        if (got !== 1'b1) begin errors++; $display("FAIL ack: no oAck within 10 cycles"); end
        checks++;
        if (oBusy !== 1'b1 || oRsp_DATA !== 16'h0000) begin
            errors++; $display("FAIL capture: busy=%b rsp=%h, required busy=1 rsp=0000", oBusy, oRsp_DATA);
        end
        exp_q.push_back(a); exp_q.push_back(t);
        exp_q.push_back(ad[23:16]); exp_q.push_back(ad[15:8]); exp_q.push_back(ad[7:0]);
        exp_q.push_back(d[15:8]); exp_q.push_back(d[7:0]); exp_q.push_back(m);
        if (len != 2'd0) rsp_q.push_back(exp_rsp);
    endtask

    task automatic tx_bytes(input int n, input int dly, input bit stray);
        for (int i = 0; i < n; i++) begin
            int waited = 0;
            bit seen = 0;
            bit ok = 1;
            logic [7:0] exp_b;
            logic [7:0] held;
            for (int k = 0; k < 20; k++) begin
                if (oTXD_Start) begin seen = 1; break; end
                tick();
                waited++;
            end
            if (!seen) begin
                checks++; errors++;
                $display("FAIL tx_start: byte %0d never started", i);
                return;
            end
            exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
            checks++;
            if (oTXD_DATA !== exp_b) begin
                errors++; $display("FAIL tx_byte%0d: got %h, required %h", i, oTXD_DATA, exp_b);
            end
            checks++;
            if (waited != 1) begin
                errors++; $display("FAIL tx_gap%0d: start low %0d cycles, required 1", i, waited);
            end
            held = oTXD_DATA;
            for (int dd = 0; dd < dly; dd++) begin
                if (stray && dd == 2) begin iRXD_DATA = 8'hEE; iRXD_Ready = 1'b1; end
                tick();
                iRXD_Ready = 1'b0;
                if (oTXD_Start !== 1'b1 || oTXD_DATA !== held) ok = 0;
            end
            if (dly > 0) begin
                checks++;
                if (!ok) begin errors++; $display("FAIL tx_hold%0d: start/data changed, required %h held", i, held); end
            end
            iTXD_Done = 1'b1;
            tick();
            iTXD_Done = 1'b0;
            checks++;
            if (oTXD_Start !== 1'b0) begin errors++; $display("FAIL tx_drop%0d: start=%b, required 0", i, oTXD_Start); end
        end
    endtask

    task automatic expect_done_norsp();
        tick();
        checks++;
        if (oRsp_Valid !== 1'b1 || oBusy !== 1'b0 || oRsp_DATA !== 16'h0) begin
            errors++; $display("FAIL done_norsp: valid=%b busy=%b rsp=%h, required 1 0 0000", oRsp_Valid, oBusy, oRsp_DATA);
        end
        tick();
        checks++;
        if (oRsp_Valid !== 1'b0) begin errors++; $display("FAIL valid_pulse: valid=%b, required 0", oRsp_Valid); end
    endtask

    task automatic rsp_bytes(input logic [7:0] b0, input logic [7:0] b1, input int n);
        logic [15:0] exp_w;
        repeat (3) tick();
        for (int j = 0; j < n; j++) begin
            iRXD_DATA = (j == 0) ? b0 : b1;
            iRXD_Ready = 1'b1;
            tick();
            iRXD_Ready = 1'b0;
            if (j < n - 1) begin
                checks++;
                if (oRsp_Valid !== 1'b0) begin errors++; $display("FAIL early_valid: valid=%b, required 0", oRsp_Valid); end
                repeat (2) tick();
            end
        end
        exp_w = (rsp_q.size() > 0) ? rsp_q.pop_front() : 16'hXXXX;
        checks++;
        if (oRsp_Valid !== 1'b1 || oRsp_DATA !== exp_w || oBusy !== 1'b0) begin
            errors++; $display("FAIL rsp: valid=%b data=%h busy=%b, required 1 %h 0", oRsp_Valid, oRsp_DATA, oBusy, exp_w);
        end
        tick();
        checks++;
        if (oRsp_Valid !== 1'b0) begin errors++; $display("FAIL rsp_pulse: valid=%b, required 0", oRsp_Valid); end
    endtask

    task automatic test_reset();
        iRST_n = 1'b0; iReq = 0; iTXD_Done = 0; iRXD_Ready = 0; iRXD_DATA = 0;
        iAction = 0; iTarget = 0; iAddr = 0; iData = 0; iMode = 0; iRsp_Len = 0;
        repeat (3) tick();
        checks++;
        if ({oAck, oTXD_Start, oRsp_Valid, oTimeout, oBusy, oTXD_DATA, oRsp_DATA} !== 29'd0) begin
            errors++; $display("FAIL reset: outputs %h, required 0", {oAck, oTXD_Start, oRsp_Valid, oTimeout, oBusy, oTXD_DATA, oRsp_DATA});
        end
        iRST_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_led_write();
        issue(ACT_WRITE, TGT_LED, 24'h000155, 16'h00AA, MODE_DISPLAY, 2'd0, 16'h0);
        tx_bytes(8, 1, 0);
        expect_done_norsp();
        repeat (120) tick();
        checks++;
        if (tmo_cnt !== 0) begin errors++; $display("FAIL led_no_timeout: timeouts=%0d, required 0", tmo_cnt); end
    endtask

    task automatic test_sdram_read();
        int v0 = val_cnt;
        issue(ACT_READ, TGT_SDRAM, 24'h123456, 16'h0000, MODE_NORMAL, 2'd2, 16'h1234);
        tx_bytes(8, 0, 0);
        rsp_bytes(8'h34, 8'h12, 2);
        checks++;
        if (val_cnt - v0 != 1) begin errors++; $display("FAIL sdram_single_valid: pulses=%0d, required 1", val_cnt - v0); end
    endtask

    task automatic test_flash_read();
        issue(ACT_READ, TGT_FLASH, 24'h000010, 16'h0000, MODE_NORMAL, 2'd1, 16'h00FF);
        tx_bytes(8, 1, 0);
        rsp_bytes(8'hFF, 8'h00, 1);
    endtask

    task automatic test_timeout();
        int v0 = val_cnt;
        int t0 = tmo_cnt;
        int k;
        bit seen = 0;
        issue(ACT_READ, TGT_SDRAM, 24'h00ABCD, 16'h0000, MODE_NORMAL, 2'd2, 16'h0000);
        void'(rsp_q.pop_back());
        tx_bytes(8, 0, 0);
        repeat (3) tick();
        iRXD_DATA = 8'h5A; iRXD_Ready = 1'b1;
        tick();
        iRXD_Ready = 1'b0;
        for (k = 1; k <= 200; k++) begin
            tick();
            if (oTimeout) begin seen = 1; break; end
        end
        checks++;
        if (!seen || k != 100) begin errors++; $display("FAIL timeout_latency: seen=%b after %0d cycles, required 100", seen, k); end
        checks++;
        if (oBusy !== 1'b0 || val_cnt != v0) begin
            errors++; $display("FAIL timeout_state: busy=%b valid_pulses=%0d, required 0 0", oBusy, val_cnt - v0);
        end
        tick();
        checks++;
        if (tmo_cnt - t0 != 1) begin errors++; $display("FAIL timeout_pulse: pulses=%0d, required 1", tmo_cnt - t0); end
        issue(ACT_WRITE, TGT_LED, 24'h000001, 16'h0002, MODE_NORMAL, 2'd0, 16'h0);
        tx_bytes(8, 0, 0);
        expect_done_norsp();
    endtask

    task automatic test_back_pressure();
        issue(ACT_READ, TGT_SDRAM, 24'hC0FFEE, 16'h9876, MODE_NORMAL, 2'd3, 16'hBEEF);
        tx_bytes(8, 37, 1);
        rsp_bytes(8'hEF, 8'hBE, 2);
    endtask

    task automatic test_reset_midframe();
        bit seen = 0;
        issue(ACT_WRITE, TGT_LED, 24'h765432, 16'h1357, MODE_DISPLAY, 2'd0, 16'h0);
        tx_bytes(3, 2, 0);
        for (int k = 0; k < 10; k++) begin
            if (oTXD_Start) begin seen = 1; break; end
            tick();
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL mid_start: byte 4 never started"); end
        iRST_n = 1'b0;
        #1;
        checks++;
        if ({oAck, oTXD_Start, oRsp_Valid, oTimeout, oBusy, oTXD_DATA, oRsp_DATA} !== 29'd0) begin
            errors++; $display("FAIL mid_reset: outputs %h, required 0", {oAck, oTXD_Start, oRsp_Valid, oTimeout, oBusy, oTXD_DATA, oRsp_DATA});
        end
        exp_q.delete();
        repeat (2) tick();
        iRST_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (oTXD_Start !== 1'b0 || oBusy !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: start=%b busy=%b, required 0 0", oTXD_Start, oBusy);
        end
        issue(ACT_WRITE, TGT_FLASH, 24'hA1B2C3, 16'hD4E5, MODE_NORMAL, 2'd0, 16'h0);
        tx_bytes(8, 1, 0);
        expect_done_norsp();
    endtask

    initial begin
        test_reset();
        test_led_write();
        test_sdram_read();
        test_flash_read();
        test_timeout();
        test_back_pressure();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
